// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, branch/jump target generation and the IF/ID
// pipeline register, with redirect > stall > sequential-fetch priority.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_pc4,
  input  logic [15:0]      br_off,
  input  logic             jmp,
  input  logic [31:0]      jmp_pc4,
  input  logic [25:0]      jmp_adr,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      inst_id,
  output logic [31:0]      pc4_id,
  output logic             valid_id,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt;
  logic        redirect;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_tgt   = br_pc4 + {{14{br_off[15]}}, br_off, 2'b00};
    j_tgt    = {jmp_pc4[31:28], jmp_adr, 2'b00};
    redirect = jr | jmp | br_taken;
    if (jr) begin
      tgt = jr_addr;
    end else if (jmp) begin
      tgt = j_tgt;
    end else begin
      tgt = br_tgt;
    end

    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;

    if (redirect) begin
      // Unaligned targets are loaded as-is; only the sticky flag records them.
      pc_d    = tgt;
      inst_d  = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      if (tgt[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d    = pc_plus4;
      inst_d  = inst_in;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out    = pc_q;
  assign inst_id   = inst_q;
  assign pc4_id    = pc4_q;
  assign valid_id  = valid_q;
  assign misalign  = mis_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed cycles push expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_fetch_unit;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic          br_taken;
  logic [31:0]   br_pc4;
  logic [15:0]   br_off;
  logic          jmp;
  logic [31:0]   jmp_pc4;
  logic [25:0]   jmp_adr;
  logic          jr;
  logic [31:0]   jr_addr;
  logic [31:0]   inst_in;
  logic [31:0]   pc_out;
  logic [31:0]   inst_id;
  logic [31:0]   pc4_id;
  logic          valid_id;
  logic          misalign;
  logic [CW-1:0] fetch_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
    logic        m;
    logic [3:0]  c;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_pc4    (br_pc4),
    .br_off    (br_off),
    .jmp       (jmp),
    .jmp_pc4   (jmp_pc4),
    .jmp_adr   (jmp_adr),
    .jr        (jr),
    .jr_addr   (jr_addr),
    .inst_in   (inst_in),
    .pc_out    (pc_out),
    .inst_id   (inst_id),
    .pc4_id    (pc4_id),
    .valid_id  (valid_id),
    .misalign  (misalign),
    .fetch_cnt (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational instruction memory model.
  function automatic logic [31:0] im(input logic [31:0] a);
    case (a)
      32'h0000_0000: im = 32'h2010_0000;
      32'h0000_0004: im = 32'h2011_0000;
      32'h0000_0008: im = 32'h0000_9024;
      32'h0000_0010: im = 32'h8c13_0004;
      32'h0000_0024: im = 32'hac12_0040;
      default:       im = 32'h0000_0000;
    endcase
  endfunction

  assign inst_in = im(pc_out);

  task automatic chk(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, exp);
    end
  endtask

  // Monitor: outputs are meaningful every cycle, so one entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "pc_out",    pc_out,            e.pc);
        chk(e.name, "inst_id",   inst_id,           e.inst);
        chk(e.name, "pc4_id",    pc4_id,            e.pc4);
        chk(e.name, "valid_id",  {31'b0, valid_id}, {31'b0, e.v});
        chk(e.name, "misalign",  {31'b0, misalign}, {31'b0, e.m});
        chk(e.name, "fetch_cnt", {28'b0, fetch_cnt}, {28'b0, e.c});
      end
    end
  end

  task automatic tick(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                      input logic [31:0] pc4, input logic v, input logic m,
                      input logic [3:0] c);
    exp_t e;
    e.name = nm;
    e.pc   = pc;
    e.inst = inst;
    e.pc4  = pc4;
    e.v    = v;
    e.m    = m;
    e.c    = c;
    sb.push_back(e);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    stall    = 1'b0;
    br_taken = 1'b0;
    jmp      = 1'b0;
    jr       = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    br_taken = 1'b0;
    br_pc4   = 32'h0;
    br_off   = 16'h0;
    jmp      = 1'b0;
    jmp_pc4  = 32'h0;
    jmp_adr  = 26'h0;
    jr       = 1'b0;
    jr_addr  = 32'h0;

    tick("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick("seq1",  32'h4, 32'h2010_0000, 32'h4, 1'b1, 1'b0, 4'd1);
    tick("seq2",  32'h8, 32'h2011_0000, 32'h8, 1'b1, 1'b0, 4'd2);
    stall = 1'b1;
    tick("stall1", 32'h8, 32'h2011_0000, 32'h8, 1'b1, 1'b0, 4'd2);
    stall = 1'b1;
    tick("stall2", 32'h8, 32'h2011_0000, 32'h8, 1'b1, 1'b0, 4'd2);
    tick("seq3",  32'hC, 32'h0000_9024, 32'hC, 1'b1, 1'b0, 4'd3);

    // Branch together with stall: redirect must win.
    br_taken = 1'b1; stall = 1'b1; br_pc4 = 32'h14; br_off = 16'h0004;
    tick("br", 32'h24, 32'h0, 32'h0, 1'b0, 1'b0, 4'd3);
    tick("br_tgt", 32'h28, 32'hac12_0040, 32'h28, 1'b1, 1'b0, 4'd4);

    jmp = 1'b1; jmp_pc4 = 32'h24; jmp_adr = 26'h000_0004;
    tick("jmp", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4);
    tick("jmp_tgt", 32'h14, 32'h8c13_0004, 32'h14, 1'b1, 1'b0, 4'd5);

    jr = 1'b1; jr_addr = 32'h100; jmp = 1'b1; br_taken = 1'b1;
    tick("jr_prio", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 4'd5);
    jmp = 1'b1; jmp_pc4 = 32'hF000_0000; jmp_adr = 26'h000_0008; br_taken = 1'b1;
    tick("jmp_prio", 32'hF000_0020, 32'h0, 32'h0, 1'b0, 1'b0, 4'd5);

    jr = 1'b1; jr_addr = 32'h42;
    tick("jr_unal", 32'h42, 32'h0, 32'h0, 1'b0, 1'b1, 4'd5);
    // IM returns 0 here: captured as a valid NOP.
    tick("nop_cap", 32'h46, 32'h0, 32'h46, 1'b1, 1'b1, 4'd6);
    jr = 1'b1; jr_addr = 32'h80;
    tick("mis_sticky", 32'h80, 32'h0, 32'h0, 1'b0, 1'b1, 4'd6);

    rst_n = 1'b0; stall = 1'b1; br_taken = 1'b1; br_pc4 = 32'h14; br_off = 16'h0004;
    tick("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);

    jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
    tick("jr_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick("pc_wrap", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1);

    // Count wraps from 15 to 0 on the 15th fetch.
    for (int i = 1; i <= 15; i++) begin
      tick("cnt_run", 32'(4 * i), im(32'(4 * (i - 1))), 32'(4 * i), 1'b1, 1'b0,
           4'((1 + i) % 16));
    end

    br_taken = 1'b1; br_pc4 = 32'h100; br_off = 16'hFFFE;
    tick("br_neg", 32'hF8, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0);
    br_taken = 1'b1; br_pc4 = 32'h101; br_off = 16'h0001;
    tick("br_unal", 32'h105, 32'h0, 32'h0, 1'b0, 1'b1, 4'd0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(posedge clk);
    end
    #3;
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
